// File: rtl/binary_activation_binary_dot_product_accum_if.sv
// Stream bundle for the binarised dot-product accumulator: two input streams joined, one result stream.
// OUT_WIDTH widens by one bit when BINARY_DOT_SIGNED_OUT_EN is defined.
interface binary_activation_binary_dot_product_accum_if #(
   parameter int unsigned IN_SIZE   = 4,
   parameter int unsigned NUM_BEATS = 4
);
   localparam int unsigned TOTAL = IN_SIZE * NUM_BEATS;
`ifdef BINARY_DOT_SIGNED_OUT_EN
   localparam int unsigned OUT_WIDTH = $clog2(TOTAL + 1) + 1;
`else
   localparam int unsigned OUT_WIDTH = $clog2(TOTAL + 1);
`endif

   logic [IN_SIZE-1:0]   data_in;
   logic                 data_in_valid;
   logic                 data_in_ready;
   logic [IN_SIZE-1:0]   weight;
   logic                 weight_valid;
   logic                 weight_ready;
   logic [OUT_WIDTH-1:0] data_out;
   logic                 data_out_valid;
   logic                 data_out_ready;

   modport master (
      output data_in, data_in_valid, weight, weight_valid, data_out_ready,
      input  data_in_ready, weight_ready, data_out, data_out_valid
   );

   modport slave (
      input  data_in, data_in_valid, weight, weight_valid, data_out_ready,
      output data_in_ready, weight_ready, data_out, data_out_valid
   );
endinterface

// File: rtl/binary_activation_binary_dot_product_accum.sv
// Streaming XNOR-popcount dot product, accumulated over NUM_BEATS beats per result.
// Optional BINARY_DOT_SIGNED_OUT_EN maps the popcount sum S to the signed value 2*S - IN_SIZE*NUM_BEATS.
module binary_activation_binary_dot_product_accum #(
   parameter int unsigned IN_SIZE   = 4,
   parameter int unsigned NUM_BEATS = 4
) (
   input  logic clk,
   input  logic rst,
   binary_activation_binary_dot_product_accum_if.slave bus
);
   localparam int unsigned TOTAL = IN_SIZE * NUM_BEATS;
`ifdef BINARY_DOT_SIGNED_OUT_EN
   localparam int unsigned OUT_WIDTH = $clog2(TOTAL + 1) + 1;
`else
   localparam int unsigned OUT_WIDTH = $clog2(TOTAL + 1);
`endif
   localparam int unsigned PC_W  = $clog2(IN_SIZE + 1);
   localparam int unsigned CNT_W = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [OUT_WIDTH-1:0] acc_q, acc_d;
   logic [OUT_WIDTH-1:0] out_q, out_d;
   logic                 out_valid_q, out_valid_d;

   logic [IN_SIZE-1:0]   match;
   logic [PC_W-1:0]      pc;
   logic [OUT_WIDTH-1:0] beat_sum;
   logic [OUT_WIDTH-1:0] out_value;
   logic                 accept;
   logic                 fire;

   // Per-element XNOR product and its popcount for the current beat
   always_comb begin
      match = ~(bus.data_in ^ bus.weight);
      pc    = '0;
      for (int unsigned i = 0; i < IN_SIZE; i++) begin
         pc = pc + PC_W'(match[i]);
      end
   end

   // The first beat of a result loads the popcount directly, so acc never needs clearing on wrap
   assign beat_sum = (cnt_q == '0) ? OUT_WIDTH'(pc) : acc_q + OUT_WIDTH'(pc);

`ifdef BINARY_DOT_SIGNED_OUT_EN
   assign out_value = (beat_sum << 1) - OUT_WIDTH'(TOTAL);
`else
   assign out_value = beat_sum;
`endif

   // Both streams join: each ready depends only on the other stream's valid and output space
   assign accept            = ~out_valid_q | bus.data_out_ready;
   assign fire              = bus.data_in_valid & bus.weight_valid & accept;
   assign bus.data_in_ready = bus.weight_valid & accept;
   assign bus.weight_ready  = bus.data_in_valid & accept;
   assign bus.data_out       = out_q;
   assign bus.data_out_valid = out_valid_q;

   // Next-state: beat counting, accumulation and output register load/release
   always_comb begin
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      out_d       = out_q;
      out_valid_d = out_valid_q;

      if (out_valid_q && bus.data_out_ready) begin
         out_valid_d = 1'b0;
      end

      if (fire) begin
         if (cnt_q == LAST_BEAT) begin
            out_d       = out_value;
            out_valid_d = 1'b1;
            cnt_d       = '0;
         end else begin
            acc_d = beat_sum;
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q       <= '0;
         acc_q       <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
      end
   end
endmodule

// File: tb/tb_binary_activation_binary_dot_product_accum.sv
// Directed bench: a 4x2 instance for accumulation, backpressure, streaming, skew and reset,
// plus a 1x1 instance for the single-beat full-rate case.
module tb_binary_activation_binary_dot_product_accum;
   localparam int unsigned TOT_A = 8;
   localparam int unsigned TOT_E = 1;
`ifdef BINARY_DOT_SIGNED_OUT_EN
   localparam int unsigned OW_A = 5;
   localparam int unsigned OW_E = 2;
`else
   localparam int unsigned OW_A = 4;
   localparam int unsigned OW_E = 1;
`endif

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   binary_activation_binary_dot_product_accum_if #(.IN_SIZE(4), .NUM_BEATS(2)) bus_a ();
   binary_activation_binary_dot_product_accum_if #(.IN_SIZE(1), .NUM_BEATS(1)) bus_e ();

   binary_activation_binary_dot_product_accum #(.IN_SIZE(4), .NUM_BEATS(2)) dut_a (
      .clk(clk), .rst(rst), .bus(bus_a.slave)
   );
   binary_activation_binary_dot_product_accum #(.IN_SIZE(1), .NUM_BEATS(1)) dut_e (
      .clk(clk), .rst(rst), .bus(bus_e.slave)
   );

   // Expected data_out for popcount sum s, masked to the output width
   function automatic logic [31:0] eo(input int s, input int total, input int ow);
      int v;
      v = s;
`ifdef BINARY_DOT_SIGNED_OUT_EN
      v = 2 * s - total;
`endif
      return 32'(v) & ((32'd1 << ow) - 32'd1);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(input logic dv, input logic [3:0] d, input logic wv, input logic [3:0] w);
      bus_a.data_in_valid = dv;
      bus_a.data_in       = d;
      bus_a.weight_valid  = wv;
      bus_a.weight        = w;
   endtask

   task automatic out_a(input string tag, input logic v, input int s);
      check({tag, "_valid"}, 32'(bus_a.data_out_valid), 32'(v));
      if (v) check({tag, "_data"}, 32'(bus_a.data_out), eo(s, TOT_A, OW_A));
   endtask

   initial begin
      rst = 1'b1;
      drive_a(1'b0, 4'h0, 1'b0, 4'h0);
      bus_a.data_out_ready = 1'b1;
      bus_e.data_in_valid  = 1'b0;
      bus_e.data_in        = 1'b0;
      bus_e.weight_valid   = 1'b0;
      bus_e.weight         = 1'b0;
      bus_e.data_out_ready = 1'b1;

      // Reset state
      tick(); tick();
      check("rst_a_valid", 32'(bus_a.data_out_valid), 32'd0);
      check("rst_a_data", 32'(bus_a.data_out), 32'd0);
      check("rst_a_dready", 32'(bus_a.data_in_ready), 32'd0);
      check("rst_a_wready", 32'(bus_a.weight_ready), 32'd0);
      check("rst_e_valid", 32'(bus_e.data_out_valid), 32'd0);
      rst = 1'b0;
      tick();

      // Basic: 1010/1010 (4) then 1111/0000 (0) -> 4
      drive_a(1'b1, 4'b1010, 1'b1, 4'b1010);
      #1;
      check("basic_dready", 32'(bus_a.data_in_ready), 32'd1);
      check("basic_wready", 32'(bus_a.weight_ready), 32'd1);
      tick();
      out_a("basic_b0", 1'b0, 0);
      drive_a(1'b1, 4'b1111, 1'b1, 4'b0000);
      tick();
      out_a("basic_res", 1'b1, 4);
      drive_a(1'b0, 4'h0, 1'b0, 4'h0);
      tick();
      out_a("basic_drop", 1'b0, 0);

      // Backpressure: all-match x2 -> 8 held while stalled, next vector queued behind it
      bus_a.data_out_ready = 1'b0;
      drive_a(1'b1, 4'b1111, 1'b1, 4'b1111);
      tick();
      tick();
      out_a("bp_res", 1'b1, 8);
      drive_a(1'b1, 4'b1100, 1'b1, 4'b1100);
      for (int k = 0; k < 5; k++) begin
         #1;
         check("bp_dready", 32'(bus_a.data_in_ready), 32'd0);
         check("bp_wready", 32'(bus_a.weight_ready), 32'd0);
         tick();
         out_a("bp_hold", 1'b1, 8);
      end
      bus_a.data_out_ready = 1'b1;
      #1;
      check("bp_release_dready", 32'(bus_a.data_in_ready), 32'd1);
      tick();
      out_a("bp_release", 1'b0, 0);
      drive_a(1'b1, 4'b0001, 1'b1, 4'b0000);
      tick();
      out_a("bp_next", 1'b1, 7);
      drive_a(1'b0, 4'h0, 1'b0, 4'h0);
      tick();

      // Streaming: 3 results x 2 beats back-to-back: 4, 6, 5
      drive_a(1'b1, 4'b1111, 1'b1, 4'b1111); tick(); out_a("st_r1b0", 1'b0, 0);
      drive_a(1'b1, 4'b0000, 1'b1, 4'b1111); tick(); out_a("st_r1", 1'b1, 4);
      drive_a(1'b1, 4'b1100, 1'b1, 4'b1010); tick(); out_a("st_r2b0", 1'b0, 0);
      drive_a(1'b1, 4'b0110, 1'b1, 4'b0110); tick(); out_a("st_r2", 1'b1, 6);
      drive_a(1'b1, 4'b1000, 1'b1, 4'b0000); tick(); out_a("st_r3b0", 1'b0, 0);
      drive_a(1'b1, 4'b0101, 1'b1, 4'b0011); tick(); out_a("st_r3", 1'b1, 5);
      drive_a(1'b0, 4'h0, 1'b0, 4'h0);
      tick();

      // Valid skew: weight alone for 3 cycles must not fire
      drive_a(1'b0, 4'b0000, 1'b1, 4'b0000);
      for (int k = 0; k < 3; k++) begin
         #1;
         check("skew_dready", 32'(bus_a.data_in_ready), 32'd1);
         check("skew_wready", 32'(bus_a.weight_ready), 32'd0);
         tick();
         out_a("skew_idle", 1'b0, 0);
      end
      drive_a(1'b1, 4'b1111, 1'b1, 4'b1111);
      #1;
      check("skew_join_wready", 32'(bus_a.weight_ready), 32'd1);
      tick();
      out_a("skew_b0", 1'b0, 0);
      tick();
      out_a("skew_res", 1'b1, 8);
      drive_a(1'b0, 4'h0, 1'b0, 4'h0);
      tick();

      // Reset mid-accumulation: partial 4 discarded, then all-mismatch x2 -> 0
      drive_a(1'b1, 4'b1111, 1'b1, 4'b1111);
      tick();
      drive_a(1'b0, 4'h0, 1'b0, 4'h0);
      rst = 1'b1;
      #1;
      check("mid_rst_valid", 32'(bus_a.data_out_valid), 32'd0);
      check("mid_rst_data", 32'(bus_a.data_out), 32'd0);
      check("mid_rst_dready", 32'(bus_a.data_in_ready), 32'd0);
      tick();
      rst = 1'b0;
      drive_a(1'b1, 4'b1111, 1'b1, 4'b0000);
      tick();
      out_a("mid_b0", 1'b0, 0);
      tick();
      out_a("mid_res", 1'b1, 0);
      drive_a(1'b0, 4'h0, 1'b0, 4'h0);
      tick();

      // Edge instance: one 1-bit beat per result, a fresh result every cycle
      bus_e.data_in_valid = 1'b1;
      bus_e.data_in       = 1'b1;
      bus_e.weight_valid  = 1'b1;
      bus_e.weight        = 1'b1;
      #1;
      check("edge_dready", 32'(bus_e.data_in_ready), 32'd1);
      tick();
      check("edge_r1_valid", 32'(bus_e.data_out_valid), 32'd1);
      check("edge_r1_data", 32'(bus_e.data_out), eo(1, TOT_E, OW_E));
      tick();
      check("edge_r2_valid", 32'(bus_e.data_out_valid), 32'd1);
      check("edge_r2_data", 32'(bus_e.data_out), eo(1, TOT_E, OW_E));
      bus_e.data_in = 1'b0;
      tick();
      check("edge_r3_valid", 32'(bus_e.data_out_valid), 32'd1);
      check("edge_r3_data", 32'(bus_e.data_out), eo(0, TOT_E, OW_E));
      bus_e.data_in        = 1'b1;
      bus_e.data_out_ready = 1'b0;
      #1;
      check("edge_stall_dready", 32'(bus_e.data_in_ready), 32'd0);
      tick();
      check("edge_stall_data", 32'(bus_e.data_out), eo(0, TOT_E, OW_E));
      bus_e.data_in_valid  = 1'b0;
      bus_e.weight_valid   = 1'b0;
      bus_e.data_out_ready = 1'b1;
      tick();
      check("edge_drop_valid", 32'(bus_e.data_out_valid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
